// File: rtl/rv_fetch_pkg.sv
// rtl/rv_fetch_pkg.sv - shared constants and width helper for the fetch queue
package rv_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    // Width of a counter that must hold 0..depth inclusive
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - flop-based instruction queue with flush, head read straight from storage flops
module fetch_fifo
    import rv_fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int CW = cnt_w(DEPTH),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;

    // Popping an empty queue is ignored so the count can never underflow
    assign w_pop = i_pop && (r_count != '0);

    // Storage, pointers and occupancy; flush empties the queue but leaves data flops alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(i_push) - CW'(w_pop);
        end
    end

    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/rv_fetch_queue.sv
// rtl/rv_fetch_queue.sv - instruction fetch request generator with in-order response queue and redirect kill
module rv_fetch_queue
    import rv_fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    localparam int             CW       = cnt_w(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] inst_data,
    output logic [XLEN-1:0]    inst_pc,
    output logic [CW-1:0]      queue_count
);

    localparam int QW = XLEN + INSTR_W;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_kill_cnt;

    logic [XLEN-1:0] w_redirect_pc;
    logic [CW:0]     w_inflight;
    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_kill_active;
    logic            w_push;
    logic            w_pop;
    logic [QW-1:0]   w_head;

    assign w_redirect_pc = {redirect_pc[XLEN-1:2], 2'b00};

    // Queued plus in-flight entries bound the requests, so every response has a free slot
    assign w_inflight    = {1'b0, queue_count} + {1'b0, r_outstanding};
    assign w_req_valid   = reset && !redirect_valid && (w_inflight < (CW+1)'(DEPTH));
    assign w_req_fire    = w_req_valid && imem_req_ready;

    // Responses to requests issued before a redirect are dropped until kill_cnt drains
    assign w_kill_active = (r_kill_cnt != '0);
    assign w_push        = imem_rsp_valid && !redirect_valid && !w_kill_active;
    assign w_pop         = inst_valid && inst_ready && !redirect_valid;

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;

    // Next address to request; redirect overrides any handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetch_pc <= w_redirect_pc;
        end else if (w_req_fire) begin
            r_fetch_pc <= r_fetch_pc + XLEN'(PC_STEP);
        end
    end

    // PC tagged onto the next accepted response, advancing only on real pushes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_rsp_pc <= w_redirect_pc;
        end else if (w_push) begin
            r_rsp_pc <= r_rsp_pc + XLEN'(PC_STEP);
        end
    end

    // Requests handed to memory whose response has not yet come back
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_outstanding <= '0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);
        end
    end

    // Stale-response counter: on redirect every outstanding request is stale, minus one answered now
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_kill_cnt <= '0;
        end else if (redirect_valid) begin
            r_kill_cnt <= r_outstanding - CW'(imem_rsp_valid);
        end else if (imem_rsp_valid && w_kill_active) begin
            r_kill_cnt <= r_kill_cnt - 1'b1;
        end
    end

    fetch_fifo #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_data  ({r_rsp_pc, imem_rsp_data}),
        .i_pop   (w_pop),
        .o_valid (inst_valid),
        .o_data  (w_head),
        .o_count (queue_count)
    );

    assign inst_data = w_head[INSTR_W-1:0];
    assign inst_pc   = w_head[QW-1:INSTR_W];

endmodule

// File: doc/rv_fetch_queue.md
RV_FETCH_QUEUE -- requirements
Module: rv_fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC/address width (>=32).
REQ-002 SHALL have parameter DEPTH, default 4, meaning instruction queue entries (power of 2, >=2).
REQ-003 SHALL have parameter RESET_PC, default 0, meaning first fetch address after reset (word aligned).
REQ-004 SHALL have port clk input 1, the single clock; all state on rising edge.
REQ-005 SHALL have port reset input 1, asynchronous active-low reset.
REQ-006 SHALL have port redirect_valid input 1, a branch/jalr redirect request.
REQ-007 SHALL have port redirect_pc input XLEN, the redirect target.
REQ-008 SHALL have port imem_req_valid output 1, a fetch request valid.
REQ-009 SHALL have port imem_req_ready input 1, meaning memory accepts the request.
REQ-010 SHALL have port imem_req_addr output XLEN, the fetch address.
REQ-011 SHALL have port imem_rsp_valid input 1, an in-order fetch response valid.
REQ-012 SHALL have port imem_rsp_data input 32, the fetched instruction.
REQ-013 SHALL have port inst_valid output 1, meaning the queue head is valid.
REQ-014 SHALL have port inst_ready input 1, meaning the decoder consumes the head.
REQ-015 SHALL have port inst_data output 32, the head instruction.
REQ-016 SHALL have port inst_pc output XLEN, the head instruction PC.
REQ-017 SHALL have port queue_count output clog2(DEPTH)+1, the valid entry count.

Function
REQ-018 Request handshake SHALL occur when imem_req_valid and imem_req_ready are both high; imem_req_addr SHALL equal fetch_pc.
REQ-019 imem_req_valid SHALL be high iff queue_count + outstanding < DEPTH and redirect_valid is low; this makes overflow impossible.
REQ-020 Each request handshake SHALL advance fetch_pc by 4 modulo 2^XLEN and increment outstanding; each response SHALL decrement it.
REQ-021 A non-killed response SHALL be written to the queue with rsp_pc; rsp_pc SHALL then advance by 4.
REQ-022 A response accepted in cycle N SHALL be visible as inst_valid/inst_data/inst_pc in cycle N+1.
REQ-023 Pop SHALL occur on inst_valid and inst_ready; outputs SHALL hold stable while inst_valid is high and inst_ready is low.
REQ-024 Simultaneous push and pop SHALL leave queue_count unchanged; a push into a queue with DEPTH-1 entries plus a pop SHALL be legal.
REQ-025 Redirect SHALL set fetch_pc and rsp_pc to {redirect_pc[XLEN-1:2],2'b00} and empty the queue next cycle; a pop in the same cycle is void.
REQ-026 Redirect SHALL set kill_cnt to outstanding minus 1 if imem_rsp_valid is high that cycle, else to outstanding.
REQ-027 A response in the redirect cycle SHALL be discarded.
REQ-028 A response while kill_cnt>0 SHALL be discarded and decrement kill_cnt; queue and rsp_pc are unchanged.
REQ-029 A redirect while kill_cnt>0 SHALL recompute kill_cnt per REQ-026, since all outstanding requests are stale.
REQ-030 Back-to-back redirects SHALL each take effect; the last one wins.
REQ-031 With single-cycle memory and inst_ready high, steady-state throughput SHALL be one instruction per cycle.

Reset
REQ-032 While reset is low: fetch_pc=rsp_pc=RESET_PC, queue_count=0, outstanding=0, kill_cnt=0, imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0.
REQ-033 The first request SHALL be presented in the first cycle after reset deasserts.
REQ-034 Reset mid-operation SHALL drop all queued and outstanding state; the memory side SHALL not return responses for pre-reset requests.

Structure
REQ-035 Shared package rv_fetch_pkg SHALL hold INSTR_W=32, PC_STEP=4 and a clog2-based count-width helper.
REQ-036 Queue storage SHALL be a sub-module fetch_fifo with parameters WIDTH and DEPTH, flush input and registered outputs, storing {pc,instr}.
REQ-037 Counters outstanding and kill_cnt SHALL be clog2(DEPTH)+1 bits wide.

Verification
REQ-038 Reset release, 1-cycle memory, inst_ready=1: inst_pc SHALL be 0,4,8,C on consecutive cycles starting 2 cycles after release.
REQ-039 inst_ready=0, DEPTH=4: queue_count SHALL reach 4, imem_req_valid SHALL be 0 with no overflow, and the head SHALL stay pc 0.
REQ-040 Redirect to 0x103 with 2 outstanding requests: 2 responses dropped, next inst_pc SHALL be 0x100, and queue_count SHALL be 0 the cycle after redirect.
REQ-041 Redirect coinciding with a response and a pop: kill_cnt SHALL be outstanding-1 and no stale instruction SHALL be delivered.
REQ-042 XLEN=32, redirect to 0xFFFFFFFC: inst_pc sequence SHALL be FFFFFFFC then 00000000 (wrap).
REQ-043 Reset asserted with a full queue mid-run: all outputs SHALL clear immediately (async), and the first post-reset inst_pc SHALL be RESET_PC.
